// File: rtl/gmii_arb_pkg.sv
// Shared types and defaults for the GMII transmit arbiter.
// Imported by the arbiter top and its round-robin picker.
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    XMIT,
    IFG
  } arb_state_e;

  localparam int IFG_CYCLES_DEF  = 12;
  localparam int SOF_TIMEOUT_DEF = 16;
  localparam int MAX_FRAME_DEF   = 1526;

  localparam int BCNT_W = 11;
  localparam int TCNT_W = 8;

  // ch1 counts as last served, so ch0 wins the first tie
  localparam logic RR_RST_LAST = 1'b1;

endpackage

// File: rtl/gmii_tx_rr_arb.sv
// Two-way round-robin pick with a last-served pointer.
// The pointer only moves when the owner reports a frame start.
module gmii_tx_rr_arb
  import gmii_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic served,
  output logic any,
  output logic pick
);

  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= RR_RST_LAST;
    end else if (upd) begin
      last <= served;
    end
  end

  assign any  = req0 | req1;
  assign pick = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Two-channel GMII transmit arbiter with IFG insertion,
// SOF timeout and MAX_FRAME overrun flagging.
module gmii_tx_arbiter
  import gmii_arb_pkg::*;
#(
  parameter int IFG_CYCLES  = IFG_CYCLES_DEF,
  parameter int SOF_TIMEOUT = SOF_TIMEOUT_DEF,
  parameter int MAX_FRAME   = MAX_FRAME_DEF
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       ch0_req,
  input  logic       ch0_tx_en,
  input  logic [7:0] ch0_txd,
  output logic       ch0_grant,
  input  logic       ch1_req,
  input  logic       ch1_tx_en,
  input  logic [7:0] ch1_txd,
  output logic       ch1_grant,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       frame_err
);

  // assert asynchronously, release on the second clock edge
  logic [1:0] rst_pipe;
  logic       rst_s;

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_s = rst_pipe[1];

  arb_state_e        state;
  logic              sel;
  logic              ovf;
  logic [BCNT_W-1:0] bcnt;
  logic [TCNT_W-1:0] tcnt;

  logic       g_req;
  logic       g_en;
  logic [7:0] g_txd;
  logic       any;
  logic       pick;
  logic       rr_upd;

  assign g_req  = sel ? ch1_req   : ch0_req;
  assign g_en   = sel ? ch1_tx_en : ch0_tx_en;
  assign g_txd  = sel ? ch1_txd   : ch0_txd;
  assign rr_upd = (state == WAIT_SOF) & g_en;

  gmii_tx_rr_arb u_rr (
    .clk    (gmii_tx_clk),
    .rst_n  (rst_s),
    .req0   (ch0_req),
    .req1   (ch1_req),
    .upd    (rr_upd),
    .served (sel),
    .any    (any),
    .pick   (pick)
  );

  always_ff @(posedge gmii_tx_clk or negedge rst_s) begin
    if (!rst_s) begin
      state      <= IDLE;
      sel        <= 1'b0;
      ovf        <= 1'b0;
      bcnt       <= '0;
      tcnt       <= '0;
      ch0_grant  <= 1'b0;
      ch1_grant  <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= '0;
      if (state == WAIT_SOF || state == XMIT) begin
        gmii_tx_en <= g_en;
        gmii_txd   <= g_txd;
      end
      unique case (state)
        IDLE: begin
          if (any) begin
            sel       <= pick;
            ch0_grant <= ~pick;
            ch1_grant <= pick;
            state     <= WAIT_SOF;
            busy      <= 1'b1;
            bcnt      <= '0;
            tcnt      <= '0;
            ovf       <= 1'b0;
          end
        end
        WAIT_SOF: begin
          if (g_en) begin
            state <= XMIT;
            bcnt  <= BCNT_W'(1);
          end else if (!g_req ||
                       tcnt == TCNT_W'(SOF_TIMEOUT - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ch0_grant <= 1'b0;
            ch1_grant <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        XMIT: begin
          if (!g_en) begin
            state     <= IFG;
            ch0_grant <= 1'b0;
            ch1_grant <= 1'b0;
            tcnt      <= '0;
          end else if (bcnt < BCNT_W'(MAX_FRAME)) begin
            bcnt <= bcnt + 1'b1;
          end else begin
            // byte beyond MAX_FRAME: count holds, flag the rest
            gmii_tx_er <= 1'b1;
            if (!ovf) begin
              frame_err <= 1'b1;
              ovf       <= 1'b1;
            end
          end
        end
        IFG: begin
          if (tcnt == TCNT_W'(IFG_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: directed frames,
// ties, SOF timeout, overrun, mid-frame reset, idle-channel noise.
module tb_gmii_tx_arbiter;

  localparam int IFG_N = 12;
  localparam int TMO_N = 16;
  localparam int MAXF  = 1526;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ch0_req, ch0_tx_en, ch1_req, ch1_tx_en;
  logic [7:0] ch0_txd, ch1_txd;
  logic       ch0_grant, ch1_grant;
  logic       gmii_tx_en, gmii_tx_er, busy, frame_err;
  logic [7:0] gmii_txd;

  gmii_tx_arbiter #(
    .IFG_CYCLES  (IFG_N),
    .SOF_TIMEOUT (TMO_N),
    .MAX_FRAME   (MAXF)
  ) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .ch0_req     (ch0_req),
    .ch0_tx_en   (ch0_tx_en),
    .ch0_txd     (ch0_txd),
    .ch0_grant   (ch0_grant),
    .ch1_req     (ch1_req),
    .ch1_tx_en   (ch1_tx_en),
    .ch1_txd     (ch1_txd),
    .ch1_grant   (ch1_grant),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       er;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ferr_cnt = 0;
  int   idle_run = 0;
  int   last_gap = 0;
  logic prev_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // monitor: pops expected bytes whenever gmii_tx_en is high
  always @(negedge clk) begin
    exp_t e;
    chk("onehot_grant", {31'd0, ch0_grant & ch1_grant}, 32'd0);
    if (gmii_tx_en) begin
      if (!prev_en) last_gap = idle_run;
      idle_run = 0;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got byte %0h want none", gmii_txd);
      end else begin
        e = sb.pop_front();
        chk("gmii_txd", {24'd0, gmii_txd}, {24'd0, e.d});
        chk("gmii_tx_er", {31'd0, gmii_tx_er}, {31'd0, e.er});
        chk("latency_cyc", cyc, e.cyc);
      end
    end else begin
      idle_run++;
      chk("idle_tx_er", {31'd0, gmii_tx_er}, 32'd0);
    end
    prev_en = gmii_tx_en;
    if (frame_err) ferr_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int ch, input logic en, input logic [7:0] d);
    if (ch == 0) begin
      ch0_tx_en = en;
      ch0_txd   = d;
    end else begin
      ch1_tx_en = en;
      ch1_txd   = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {ch0_req, ch0_tx_en, ch1_req, ch1_tx_en} = 4'b0;
    ch0_txd = 8'h00;
    ch1_txd = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // call at posedge+1 with the channel already granted
  task automatic send_bytes(input int ch, input int n,
                            input logic [7:0] first, input bit tog);
    logic [7:0] d;
    for (int i = 1; i <= n; i++) begin
      d = first + 8'(i - 1);
      drv(ch, 1'b1, d);
      sb.push_back('{d: d, er: (i > MAXF), cyc: cyc + 1});
      if (tog) begin
        ch1_tx_en = i[0];
        ch1_txd   = 8'hA5 ^ 8'(i);
      end
      step();
    end
  endtask

  task automatic end_frame(input int ch, input string name);
    int idle;
    int k;
    drv(ch, 1'b0, 8'h00);
    if (ch == 0) ch0_req = 1'b0;
    else ch1_req = 1'b0;
    idle = 0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (!busy) break;
      if (!gmii_tx_en) idle++;
    end
    chk({name, "_busy_drop"}, {31'd0, busy}, 32'd0);
    chk({name, "_ifg"}, idle, IFG_N);
    chk({name, "_sb_drain"}, sb.size(), 0);
  endtask

  task automatic wait_grant(output int k);
    k = 0;
    while (!(ch0_grant | ch1_grant) && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int f0;
    do_reset();
    rst_n = 1'b0;
    #3;
    chk("reset_outputs",
        {20'd0, ch0_grant, ch1_grant, gmii_tx_en, gmii_tx_er,
         gmii_txd, busy, frame_err}, 32'd0);
    do_reset();

    // ch0 alone, 64 bytes from 0x55
    ch0_req = 1'b1;
    step();
    chk("t27_grant", {30'd0, ch0_grant, ch1_grant}, 32'd2);
    chk("t27_busy", {31'd0, busy}, 32'd1);
    send_bytes(0, 64, 8'h55, 1'b0);
    end_frame(0, "t27");

    // tie after reset: ch0 first, then ch1
    do_reset();
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    step();
    chk("t28_tie", {30'd0, ch0_grant, ch1_grant}, 32'd2);
    send_bytes(0, 100, 8'h00, 1'b0);
    end_frame(0, "t28a");
    wait_grant(k);
    chk("t28_g1", {30'd0, ch0_grant, ch1_grant}, 32'd1);
    step();
    send_bytes(1, 100, 8'h80, 1'b0);
    chk("t28_gap_ge_ifg", {31'd0, last_gap >= IFG_N}, 32'd1);
    end_frame(1, "t28b");

    // ch1 times out, ch0 follows without IFG
    do_reset();
    ch1_req = 1'b1;
    step();
    chk("t29_g1", {30'd0, ch0_grant, ch1_grant}, 32'd1);
    ch0_req = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (ch1_grant) k++;
      else break;
    end
    chk("t29_tmo_len", k, TMO_N);
    chk("t29_no_ifg", {31'd0, busy}, 32'd0);
    wait_grant(k);
    chk("t29_g0_wait", k, 1);
    chk("t29_g0", {30'd0, ch0_grant, ch1_grant}, 32'd2);
    step();
    send_bytes(0, 8, 8'h10, 1'b0);
    end_frame(0, "t29");
    step();
    ch0_req = 1'b1;
    wait_grant(k);
    chk("t29_ch1_prio", {30'd0, ch0_grant, ch1_grant}, 32'd1);
    step();
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    step();
    chk("t29_withdraw", {30'd0, busy, ch1_grant}, 32'd0);

    // overrun: 1530 bytes, tx_er on 1527..1530
    do_reset();
    ch0_req = 1'b1;
    step();
    chk("t30_grant", {30'd0, ch0_grant, ch1_grant}, 32'd2);
    f0 = ferr_cnt;
    send_bytes(0, 1530, 8'h01, 1'b0);
    end_frame(0, "t30");
    chk("t30_ferr_pulses", ferr_cnt - f0, 1);

    // reset at byte 30 of a ch1 frame
    do_reset();
    ch1_req = 1'b1;
    step();
    chk("t31_grant", {30'd0, ch0_grant, ch1_grant}, 32'd1);
    send_bytes(1, 29, 8'h30, 1'b0);
    #5;
    drv(1, 1'b1, 8'hEE);
    rst_n = 1'b0;
    #1;
    chk("t31_async_clr",
        {28'd0, gmii_tx_en, ch0_grant, ch1_grant, busy}, 32'd0);
    chk("t31_sb_empty", sb.size(), 0);
    do_reset();
    chk("t31_no_ifg", {31'd0, busy}, 32'd0);
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    step();
    chk("t31_tie_ch0", {30'd0, ch0_grant, ch1_grant}, 32'd2);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    step();

    // ch1 toggles while not granted
    do_reset();
    ch0_req = 1'b1;
    step();
    chk("t32_grant", {30'd0, ch0_grant, ch1_grant}, 32'd2);
    send_bytes(0, 40, 8'hC0, 1'b1);
    drv(1, 1'b0, 8'h00);
    end_frame(0, "t32");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
